// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing constants for the pushbutton conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  localparam logic KEY_PRESSED_LVL = 1'b0;

  localparam int KEY_DEBOUNCE_CYCLES_DEF     = 1_000_000;
  localparam int KEY_REPEAT_DELAY_CYCLES_DEF = 25_000_000;
  localparam int KEY_REPEAT_RATE_CYCLES_DEF  = 10_000_000;

  function automatic int key_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset value; also used for SW inputs.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low key into press/release strobes and a clean level.
// Optional auto-repeat strobe is built only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = KEY_DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY_CYCLES = KEY_REPEAT_DELAY_CYCLES_DEF,
  parameter int REPEAT_RATE_CYCLES  = KEY_REPEAT_RATE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic key_level,
  output logic repeat_pulse
);

  localparam int CNT_MAX = key_max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       key_s;
  logic       pressed;
  key_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic       press_nxt;
  logic       release_nxt;
  logic       level_nxt;

  // Stage 0: bring the asynchronous key into the clk domain (reset to released)
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_n),
    .q   (key_s)
  );

  assign pressed = (key_s == KEY_PRESSED_LVL);

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

  // rep_phase = 0 while waiting out the initial delay, 1 once repeating at the rate
  logic rep_phase, rep_phase_nxt;
  logic repeat_nxt;
  logic repeat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_phase <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      rep_phase <= rep_phase_nxt;
      repeat_q  <= repeat_nxt;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  // Stage 1: state, shared counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      key_level     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      key_level     <= level_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    rep_phase_nxt = rep_phase;
    repeat_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pressed) begin
          state_nxt = PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (!pressed) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
          rep_phase_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
          if ((!rep_phase && cnt == DELAY_LAST) || (rep_phase && cnt == RATE_LAST)) begin
            repeat_nxt    = 1'b1;
            rep_phase_nxt = 1'b1;
            cnt_nxt       = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      RELEASE_CHK: begin
        // A bounce back to pressed resumes HELD silently; repeat restarts from the delay
        if (pressed) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
          rep_phase_nxt = 1'b0;
`endif
        end else if (cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_CHK);
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed and randomized bench for key_debounce against a run-length reference model.
module tb_key_debounce;

  localparam int D     = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 3;
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int REP_EN = 1;
`else
  localparam int REP_EN = 0;
`endif

  logic clk;
  logic rst;
  logic key_n;
  logic press_pulse;
  logic release_pulse;
  logic key_level;
  logic repeat_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_DELAY_CYCLES (DELAY),
    .REPEAT_RATE_CYCLES  (RATE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_n         (key_n),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .key_level     (key_level),
    .repeat_pulse  (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: synchroniser pipe plus run lengths of pressed/released samples
  logic m_s1, m_s2, m_level;
  int   m_prun, m_rrun, m_hold;
  logic e_press, e_rel, e_rep;

  // per-scenario statistics
  int edges;
  int press_cnt, rel_cnt, rep_cnt;
  int first_press, first_rel, first_rep, last_rep, level_rise, level_fall;
  logic prev_level;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
    m_prun = 0; m_rrun = 0; m_hold = 0;
    e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
  endtask

  task automatic model_step();
    logic sample;
    logic pr;
    if (rst) begin
      model_reset();
      return;
    end
    sample = m_s2;
    m_s2   = m_s1;
    m_s1   = key_n;
    pr     = (sample == 1'b0);
    e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
    if (!m_level) begin
      if (pr) begin
        m_prun++;
        if (m_prun == D + 1) begin
          e_press = 1'b1; m_level = 1'b1;
          m_prun = 0; m_rrun = 0; m_hold = 0;
        end
      end else begin
        m_prun = 0;
      end
    end else begin
      if (pr) begin
        if (m_rrun > 0) begin
          m_rrun = 0; m_hold = 0;
        end else begin
          m_hold++;
          if (REP_EN != 0 && (m_hold == DELAY || (m_hold > DELAY && (m_hold - DELAY) % RATE == 0)))
            e_rep = 1'b1;
        end
      end else begin
        m_rrun++;
        if (m_rrun == D + 1) begin
          e_rel = 1'b1; m_level = 1'b0; m_rrun = 0;
        end
      end
    end
  endtask

  task automatic clear_stats();
    edges = 0;
    press_cnt = 0; rel_cnt = 0; rep_cnt = 0;
    first_press = 0; first_rel = 0; first_rep = 0; last_rep = 0;
    level_rise = 0; level_fall = 0;
    prev_level = key_level;
  endtask

  task automatic tick();
    @(posedge clk);
    edges++;
    model_step();
    #1;
    chk("press_pulse", int'(press_pulse), int'(e_press));
    chk("release_pulse", int'(release_pulse), int'(e_rel));
    chk("key_level", int'(key_level), int'(m_level));
    chk("repeat_pulse", int'(repeat_pulse), int'(e_rep));
    if (press_pulse) begin press_cnt++; if (first_press == 0) first_press = edges; end
    if (release_pulse) begin rel_cnt++; if (first_rel == 0) first_rel = edges; end
    if (repeat_pulse) begin
      rep_cnt++; last_rep = edges;
      if (first_rep == 0) first_rep = edges;
    end
    if (key_level && !prev_level && level_rise == 0) level_rise = edges;
    if (!key_level && prev_level && level_fall == 0) level_fall = edges;
    prev_level = key_level;
  endtask

  initial begin
    rst = 1'b1;
    key_n = 1'b1;
    model_reset();
    clear_stats();
    repeat (3) tick();
    chk("reset_level", int'(key_level), 0);
    chk("reset_press", int'(press_pulse), 0);
    rst = 1'b0;
    repeat (4) tick();

    // clean press held long enough for three repeats
    clear_stats();
    key_n = 1'b0;
    repeat (25) tick();
    chk("clean_press_edge", first_press, 7);
    chk("clean_press_count", press_cnt, 1);
    chk("clean_level_edge", level_rise, 7);
    chk("repeat_count", rep_cnt, REP_EN * 3);
    chk("repeat_first", first_rep, REP_EN * 17);
    chk("repeat_last", last_rep, REP_EN * 23);

    // clean release
    clear_stats();
    key_n = 1'b1;
    repeat (12) tick();
    chk("release_edge", first_rel, 7);
    chk("release_level_edge", level_fall, 7);
    chk("release_count", rel_cnt, 1);
    chk("release_no_press", press_cnt, 0);

    // bounce: low 2, high 1, then low
    clear_stats();
    key_n = 1'b0; tick(); tick();
    key_n = 1'b1; tick();
    key_n = 1'b0;
    repeat (12) tick();
    chk("bounce_press_count", press_cnt, 1);
    chk("bounce_press_edge", first_press, 10);

    // short release glitch while held is swallowed
    clear_stats();
    key_n = 1'b1; repeat (3) tick();
    key_n = 1'b0; repeat (10) tick();
    chk("glitch_release_count", rel_cnt, 0);
    chk("glitch_press_count", press_cnt, 0);
    chk("glitch_level", int'(key_level), 1);
    key_n = 1'b1;
    repeat (10) tick();

    // reset mid-hold
    clear_stats();
    key_n = 1'b0;
    repeat (12) tick();
    chk("pre_reset_level", int'(key_level), 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_level", int'(key_level), 0);
    chk("async_rst_release", int'(release_pulse), 0);
    chk("async_rst_press", int'(press_pulse), 0);
    tick(); tick();
    rst = 1'b0;
    clear_stats();
    repeat (10) tick();
    chk("post_reset_press_edge", first_press, 7);
    chk("post_reset_release_count", rel_cnt, 0);

    // randomized bursts
    key_n = 1'b1;
    repeat (10) tick();
    for (int b = 0; b < 80; b++) begin
      int len;
      key_n = ~key_n;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 8));
      repeat (len) tick();
    end
    key_n = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
